// File: rtl/fp8_addsub_arbiter_if.sv
// Requester/response bundle for fp8_addsub_arbiter: two operand ports and one response channel.
// master = requester/consumer side, slave = arbiter side.
interface fp8_addsub_arbiter_if;
  logic [1:0] req_valid;
  logic [1:0] req_ready;
  logic [7:0] req_a0;
  logic [7:0] req_b0;
  logic       req_op0;
  logic [7:0] req_a1;
  logic [7:0] req_b1;
  logic       req_op1;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_result;
  logic [4:0] rsp_flags;
  logic       rsp_id;

  modport master (
    output req_valid, req_a0, req_b0, req_op0, req_a1, req_b1, req_op1, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_flags, rsp_id
  );

  modport slave (
    input  req_valid, req_a0, req_b0, req_op0, req_a1, req_b1, req_op1, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_flags, rsp_id
  );
endinterface

// File: rtl/fp8_addsub_arbiter.sv
// Two-port arbiter/sequencer around one FP8 (1|3|4, bias 3) adder/subtractor FPAddSub.
// Define FP8_ARB_FIXED_PRIO_EN for fixed priority (port 0 wins ties); default is round-robin.

// flags = {invalid, overflow, underflow, inexact, zero}; round to nearest even, exp 7 = inf/NaN.
module FPAddSub (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       operation,
  output logic [7:0] result,
  output logic [4:0] flags
);
  logic        sa, sb, a_nan, b_nan, a_inf, b_inf, swap;
  logic        s_big, s_sml, sign_out, rnd_up, inexact;
  logic [2:0]  ea, eb, e_big, e_sml, d, lz, shamt;
  logic [4:0]  sig_big, sig_sml;
  logic [15:0] al_wide;
  logic [7:0]  al, norm;
  logic [8:0]  sum;
  logic [3:0]  e_n, e_fin;
  logic [5:0]  m5;

  always_comb begin
    sa      = a[7];
    sb      = b[7] ^ operation;
    ea      = a[6:4];
    eb      = b[6:4];
    a_nan   = (ea == 3'd7) && (a[3:0] != 4'd0);
    b_nan   = (eb == 3'd7) && (b[3:0] != 4'd0);
    a_inf   = (ea == 3'd7) && (a[3:0] == 4'd0);
    b_inf   = (eb == 3'd7) && (b[3:0] == 4'd0);
    swap    = b[6:0] > a[6:0];
    s_big   = swap ? sb : sa;
    s_sml   = swap ? sa : sb;
    e_big   = swap ? ((eb == 3'd0) ? 3'd1 : eb) : ((ea == 3'd0) ? 3'd1 : ea);
    e_sml   = swap ? ((ea == 3'd0) ? 3'd1 : ea) : ((eb == 3'd0) ? 3'd1 : eb);
    sig_big = swap ? {eb != 3'd0, b[3:0]} : {ea != 3'd0, a[3:0]};
    sig_sml = swap ? {ea != 3'd0, a[3:0]} : {eb != 3'd0, b[3:0]};
    d       = e_big - e_sml;
    // three guard positions below the mantissa; bits shifted past them fold into a sticky bit
    al_wide = {sig_sml, 11'b0} >> d;
    al      = {al_wide[15:9], al_wide[8] | (|al_wide[7:0])};
    if (s_big == s_sml) sum = {1'b0, sig_big, 3'b0} + {1'b0, al};
    else                sum = {1'b0, sig_big, 3'b0} - {1'b0, al};

    lz = 3'd7;
    for (int i = 0; i < 8; i++) begin
      if (sum[i]) lz = 3'(7 - i);
    end
    shamt = (lz > (e_big - 3'd1)) ? (e_big - 3'd1) : lz;
    if (sum[8]) begin
      norm = {sum[8:2], sum[1] | sum[0]};
      e_n  = {1'b0, e_big} + 4'd1;
    end else begin
      norm = sum[7:0] << shamt;
      e_n  = {1'b0, e_big} - {1'b0, shamt};
    end

    inexact  = |norm[2:0];
    rnd_up   = norm[2] & (norm[3] | norm[1] | norm[0]);
    m5       = {1'b0, norm[7:3]} + {5'b0, rnd_up};
    e_fin    = m5[5] ? (e_n + 4'd1) : (m5[4] ? e_n : 4'd0);
    sign_out = (m5 == 6'd0 && s_big != s_sml) ? 1'b0 : s_big;

    if (a_nan || b_nan || (a_inf && b_inf && (sa != sb))) begin
      result = 8'h78;
      flags  = 5'b10000;
    end else if (a_inf) begin
      result = {sa, 7'h70};
      flags  = 5'b00000;
    end else if (b_inf) begin
      result = {sb, 7'h70};
      flags  = 5'b00000;
    end else if (e_fin >= 4'd7) begin
      result = {sign_out, 7'h70};
      flags  = 5'b01010;
    end else begin
      result = {sign_out, e_fin[2:0], m5[3:0]};
      flags  = {2'b00, (e_fin == 4'd0) && inexact, inexact, m5 == 6'd0};
    end
  end
endmodule

// state | meaning
// IDLE  | arbitrate, handshake latches operands of the granted port
// EXEC  | FPAddSub evaluates from operand registers, result captured at end
// RESP  | rsp_valid high, held until rsp_ready
module fp8_addsub_arbiter #(
  parameter int NREQ = 2
) (
  input logic                 clk,
  input logic                 rst,
  fp8_addsub_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t          state_q, state_d;
  logic [NREQ-1:0] grant;
  logic            pick1, hs, gnt_id;
  logic [7:0]      a_q, b_q, rsp_result_q, fp_result;
  logic            op_q, id_q, rsp_id_q;
  logic [4:0]      rsp_flags_q, fp_flags;
`ifndef FP8_ARB_FIXED_PRIO_EN
  logic            last_q;
`endif

`ifdef FP8_ARB_FIXED_PRIO_EN
  assign pick1 = bus.req_valid[1] & ~bus.req_valid[0];
`else
  assign pick1 = bus.req_valid[1] & (~bus.req_valid[0] | ~last_q);
`endif

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    grant   = '0;
    case (state_q)
      IDLE: begin
        if (!rst) grant = {pick1, bus.req_valid[0] & ~pick1};
        if (|grant) state_d = EXEC;
      end
      EXEC:    state_d = RESP;
      RESP:    if (bus.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign hs     = |(bus.req_valid & grant);
  assign gnt_id = grant[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q          <= 8'h00;
      b_q          <= 8'h00;
      op_q         <= 1'b0;
      id_q         <= 1'b0;
      rsp_result_q <= 8'h00;
      rsp_flags_q  <= 5'h00;
      rsp_id_q     <= 1'b0;
`ifndef FP8_ARB_FIXED_PRIO_EN
      last_q       <= 1'b1;
`endif
    end else begin
      if (hs) begin
        a_q  <= gnt_id ? bus.req_a1  : bus.req_a0;
        b_q  <= gnt_id ? bus.req_b1  : bus.req_b0;
        op_q <= gnt_id ? bus.req_op1 : bus.req_op0;
        id_q <= gnt_id;
`ifndef FP8_ARB_FIXED_PRIO_EN
        last_q <= gnt_id;
`endif
      end
      if (state_q == EXEC) begin
        rsp_result_q <= fp_result;
        rsp_flags_q  <= fp_flags;
        rsp_id_q     <= id_q;
      end
    end
  end

  FPAddSub u_fpaddsub (
    .a         (a_q),
    .b         (b_q),
    .operation (op_q),
    .result    (fp_result),
    .flags     (fp_flags)
  );

  assign bus.req_ready  = grant;
  assign bus.rsp_valid  = (state_q == RESP);
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_flags  = rsp_flags_q;
  assign bus.rsp_id     = rsp_id_q;
endmodule

// File: tb/tb_fp8_addsub_arbiter.sv
// Directed + random bench for fp8_addsub_arbiter; cycle model of the handshake with a response scoreboard.
module tb_fp8_addsub_arbiter;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fp8_addsub_arbiter_if bus ();
  fp8_addsub_arbiter #(.NREQ(2)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct packed {
    logic [7:0] res;
    logic [4:0] flg;
    logic       chk_flg;
    logic       id;
  } exp_t;

  exp_t       sb_q[$];
  logic       ids_seen[$];
  logic [7:0] exp_res [2];
  logic [4:0] exp_flg [2];
  logic       chk_flg [2];
  int         n_assert = 0;
  int         n_fail   = 0;
  int         m_state  = 0;
  logic       m_last   = 1'b1;
  logic [3:0] exp_ids;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_assert++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // one clock: check outputs at the falling edge, advance the model after the rising edge
  task automatic step();
    logic [1:0] exp_rdy;
    logic       hs, rel, gid;
    exp_t       e;
    @(negedge clk);
    exp_rdy = 2'b00;
    if (!rst && m_state == 0) begin
      if (bus.req_valid == 2'b01)      exp_rdy = 2'b01;
      else if (bus.req_valid == 2'b10) exp_rdy = 2'b10;
      else if (bus.req_valid == 2'b11) begin
`ifdef FP8_ARB_FIXED_PRIO_EN
        exp_rdy = 2'b01;
`else
        exp_rdy = m_last ? 2'b01 : 2'b10;
`endif
      end
    end
    chk("req_ready", bus.req_ready, exp_rdy);
    chk("ready_onehot", $countones(bus.req_ready) <= 1, 1);
    chk("ready_without_valid", (bus.req_ready & ~bus.req_valid) == 2'b00, 1);
    chk("rsp_valid", bus.rsp_valid, m_state == 2);
    hs  = |(bus.req_valid & exp_rdy);
    gid = exp_rdy[1];
    rel = 1'b0;
    if (m_state == 2 && sb_q.size() > 0) begin
      chk("rsp_result", bus.rsp_result, sb_q[0].res);
      chk("rsp_id", bus.rsp_id, sb_q[0].id);
      if (sb_q[0].chk_flg) chk("rsp_flags", bus.rsp_flags, sb_q[0].flg);
      rel = bus.rsp_ready;
    end
    @(posedge clk);
    #1;
    if (rst) begin
      m_state = 0;
      m_last  = 1'b1;
      sb_q.delete();
    end else begin
      case (m_state)
        0: if (hs) begin
          e.res = exp_res[gid]; e.flg = exp_flg[gid]; e.chk_flg = chk_flg[gid]; e.id = gid;
          sb_q.push_back(e);
          m_last  = gid;
          m_state = 1;
        end
        1: m_state = 2;
        2: if (rel) begin
          ids_seen.push_back(sb_q[0].id);
          void'(sb_q.pop_front());
          m_state = 0;
        end
        default: m_state = 0;
      endcase
    end
  endtask

  task automatic wait_grant(input int max);
    for (int i = 0; i < max && m_state == 0; i++) step();
    chk("grant_timeout", m_state != 0, 1);
  endtask

  task automatic wait_rsp(input int max);
    for (int i = 0; i < max && sb_q.size() > 0; i++) step();
    chk("rsp_timeout", sb_q.size(), 0);
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_rsp_valid"}, bus.rsp_valid, 0);
    chk({tag, "_rsp_result"}, bus.rsp_result, 8'h00);
    chk({tag, "_rsp_flags"}, bus.rsp_flags, 5'h00);
    chk({tag, "_rsp_id"}, bus.rsp_id, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req_valid = 2'b00;
    step();
    step();
    rst = 1'b0;
    check_zero_outputs("reset");
  endtask

  task automatic set_port(input int p, input logic [7:0] a, input logic [7:0] b, input logic op,
                          input logic [7:0] r, input logic [4:0] f, input logic cf);
    if (p == 0) begin bus.req_a0 = a; bus.req_b0 = b; bus.req_op0 = op; end
    else        begin bus.req_a1 = a; bus.req_b1 = b; bus.req_op1 = op; end
    exp_res[p] = r; exp_flg[p] = f; chk_flg[p] = cf;
  endtask

  initial begin
    rst = 1'b1;
    bus.req_valid = 2'b00;
    bus.rsp_ready = 1'b0;
    set_port(0, 8'h00, 8'h00, 1'b0, 8'h00, 5'h00, 1'b0);
    set_port(1, 8'h00, 8'h00, 1'b0, 8'h00, 5'h00, 1'b0);
    do_reset();

    // 1.0 + 1.0 on port 0
    bus.rsp_ready = 1'b1;
    set_port(0, 8'h30, 8'h30, 1'b0, 8'h40, 5'h00, 1'b1);
    bus.req_valid = 2'b01;
    wait_grant(10);
    bus.req_valid = 2'b00;
    wait_rsp(10);

    // port 1: 1.5 + 2.0, then 1.5 - 1.5
    set_port(1, 8'h38, 8'h40, 1'b0, 8'h4C, 5'h00, 1'b1);
    bus.req_valid = 2'b10;
    wait_grant(10);
    bus.req_valid = 2'b00;
    wait_rsp(10);
    set_port(1, 8'h38, 8'h38, 1'b1, 8'h00, 5'h00, 1'b0);
    bus.req_valid = 2'b10;
    wait_grant(10);
    bus.req_valid = 2'b00;
    wait_rsp(10);

    // both ports continuously valid
    do_reset();
    set_port(0, 8'h30, 8'h30, 1'b0, 8'h40, 5'h00, 1'b1);
    set_port(1, 8'h38, 8'h40, 1'b0, 8'h4C, 5'h00, 1'b1);
    bus.rsp_ready = 1'b1;
    ids_seen.delete();
    bus.req_valid = 2'b11;
    for (int i = 0; i < 40 && ids_seen.size() < 4; i++) step();
    bus.req_valid = 2'b00;
    wait_rsp(10);
    chk("tie_count", ids_seen.size(), 4);
`ifdef FP8_ARB_FIXED_PRIO_EN
    exp_ids = 4'b0000;
`else
    exp_ids = 4'b1010;
`endif
    for (int i = 0; i < 4 && i < ids_seen.size(); i++) chk("tie_id", ids_seen[i], exp_ids[i]);

    // backpressure with port 1 pending
    bus.rsp_ready = 1'b0;
    bus.req_valid = 2'b01;
    wait_grant(10);
    bus.req_valid = 2'b10;
    for (int i = 0; i < 10 && m_state != 2; i++) step();
    for (int i = 0; i < 5; i++) step();
    chk("held_rsp_valid", bus.rsp_valid, 1);
    chk("held_rsp_result", bus.rsp_result, 8'h40);
    bus.rsp_ready = 1'b1;
    step();
    chk("release_idle", m_state, 0);
    step();
    chk("grant_after_release", m_state, 1);
    bus.req_valid = 2'b00;
    wait_rsp(10);

    // reset while port 0 is in EXEC
    bus.req_valid = 2'b01;
    wait_grant(10);
    bus.req_valid = 2'b00;
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_zero_outputs("mid_exec_reset");
    for (int i = 0; i < 4; i++) step();
    bus.req_valid = 2'b11;
    wait_grant(10);
    bus.req_valid = 2'b00;
    wait_rsp(10);
    chk("post_reset_tie_id", bus.rsp_id, 0);

    // random valid / rsp_ready
    for (int i = 0; i < 200; i++) begin
      bus.req_valid = 2'($urandom_range(0, 3));
      bus.rsp_ready = 1'($urandom_range(0, 1));
      step();
    end
    bus.req_valid = 2'b00;
    bus.rsp_ready = 1'b1;
    wait_rsp(20);
    step();
    chk("drain_idle", m_state, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
